// File: rtl/fpu_offload_issuer.sv
// Core-side issuer for the FP coprocessor: holds one instruction, tags it with an ID, tracks in-flight IDs, returns writebacks.
// Optional FPU_OFFLOAD_INORDER_CHECK_EN: flag results that retire out of issue order.
module fpu_offload_issuer #(
  parameter int X_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN            = 32,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic                  flush,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [31:0]           issue_instr,
  output logic [X_ID_WIDTH-1:0] issue_id,
  output logic [XLEN-1:0]       issue_rs1,
  input  logic                  result_valid,
  output logic                  result_ready,
  input  logic [X_ID_WIDTH-1:0] result_id,
  input  logic                  result_we,
  input  logic [XLEN-1:0]       result_data,
  output logic                  wb_valid,
  output logic [X_ID_WIDTH-1:0] wb_id,
  output logic [XLEN-1:0]       wb_data,
  output logic [CW-1:0]         outstanding,
  output logic                  err
);
  localparam int NIDS = 2 ** X_ID_WIDTH;

  logic                  hold_valid_reg;
  logic [31:0]           hold_instr_reg;
  logic [XLEN-1:0]       hold_rs1_reg;
  logic [X_ID_WIDTH-1:0] hold_id_reg;
  logic [X_ID_WIDTH-1:0] next_id_reg;
  logic [NIDS-1:0]       sb_reg, sb_next;
  logic [CW-1:0]         out_reg;
  logic                  err_reg;
  logic                  wb_valid_reg;
  logic [X_ID_WIDTH-1:0] wb_id_reg;
  logic [XLEN-1:0]       wb_data_reg;
  logic                  accept, fire, hit, order_err;

  assign instr_ready = !rst && !hold_valid_reg && (out_reg < CW'(MAX_OUTSTANDING))
                       && !sb_reg[next_id_reg] && !flush;
  assign accept      = instr_valid && instr_ready;
  assign issue_valid = hold_valid_reg && !flush;
  assign fire        = issue_valid && issue_ready;
  assign hit         = result_valid && sb_reg[result_id];

  // Set from the issue is applied first so a same-cycle retire of an outstanding ID still clears it.
  always_comb begin
    sb_next = sb_reg;
    if (fire) sb_next[hold_id_reg] = 1'b1;
    if (hit)  sb_next[result_id]   = 1'b0;
  end

`ifdef FPU_OFFLOAD_INORDER_CHECK_EN
  logic [X_ID_WIDTH-1:0]      fifo_reg  [MAX_OUTSTANDING];
  logic [X_ID_WIDTH-1:0]      fifo_next [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] match;
  logic [MAX_OUTSTANDING-1:0] seen;
  logic [CW-1:0]              tail;

  assign tail      = out_reg - CW'(hit);
  assign order_err = hit && (fifo_reg[0] != result_id);

  // Retiring entry is squeezed out by shifting everything behind it one slot toward the head.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_fifo
    logic [X_ID_WIDTH-1:0] shifted;
    assign match[gi] = hit && (CW'(gi) < out_reg) && (fifo_reg[gi] == result_id);
    if (gi == 0) begin : g_first
      assign seen[gi] = match[gi];
    end else begin : g_rest
      assign seen[gi] = seen[gi-1] | match[gi];
    end
    if (gi == MAX_OUTSTANDING - 1) begin : g_last
      assign shifted = seen[gi] ? '0 : fifo_reg[gi];
    end else begin : g_mid
      assign shifted = seen[gi] ? fifo_reg[gi+1] : fifo_reg[gi];
    end
    assign fifo_next[gi] = (fire && (CW'(gi) == tail)) ? hold_id_reg : shifted;
  end

  always_ff @(posedge ck) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      fifo_reg[i] <= rst ? '0 : fifo_next[i];
    end
  end
`else
  assign order_err = 1'b0;
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
      hold_instr_reg <= '0;
      hold_rs1_reg   <= '0;
      hold_id_reg    <= '0;
      next_id_reg    <= '0;
      sb_reg         <= '0;
      out_reg        <= '0;
      err_reg        <= 1'b0;
      wb_valid_reg   <= 1'b0;
      wb_id_reg      <= '0;
      wb_data_reg    <= '0;
    end else begin
      if (accept) begin
        hold_valid_reg <= 1'b1;
        hold_instr_reg <= instr;
        hold_rs1_reg   <= rs1_data;
        hold_id_reg    <= next_id_reg;
      end
      if (flush || fire) hold_valid_reg <= 1'b0;
      if (fire) next_id_reg <= next_id_reg + X_ID_WIDTH'(1);
      sb_reg       <= sb_next;
      out_reg      <= out_reg + CW'(fire) - CW'(hit);
      err_reg      <= err_reg | (result_valid && !hit) | order_err;
      wb_valid_reg <= hit && result_we;
      if (hit && result_we) begin
        wb_id_reg   <= result_id;
        wb_data_reg <= result_data;
      end
    end
  end

  assign issue_instr  = hold_instr_reg;
  assign issue_id     = hold_id_reg;
  assign issue_rs1    = hold_rs1_reg;
  assign result_ready = 1'b1;
  assign wb_valid     = wb_valid_reg;
  assign wb_id        = wb_id_reg;
  assign wb_data      = wb_data_reg;
  assign outstanding  = out_reg;
  assign err          = err_reg;
endmodule

// File: tb/tb_fpu_offload_issuer.sv
// Bench for fpu_offload_issuer: directed scenarios plus random traffic, checked each cycle against a queue-based model.
module tb_fpu_offload_issuer;
  localparam int IDW  = 4;
  localparam int MAXO = 4;
  localparam int XLEN = 32;
  localparam int NIDS = 16;

  logic            ck = 1'b0;
  logic            rst;
  logic            instr_valid, instr_ready, flush;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic            issue_valid, issue_ready;
  logic [31:0]     issue_instr;
  logic [IDW-1:0]  issue_id;
  logic [XLEN-1:0] issue_rs1;
  logic            result_valid, result_ready, result_we;
  logic [IDW-1:0]  result_id;
  logic [XLEN-1:0] result_data;
  logic            wb_valid;
  logic [IDW-1:0]  wb_id;
  logic [XLEN-1:0] wb_data;
  logic [2:0]      outstanding;
  logic            err;

  fpu_offload_issuer #(.X_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .XLEN(XLEN)) dut (
    .ck(ck), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .rs1_data(rs1_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_id(issue_id), .issue_rs1(issue_rs1),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_we(result_we), .result_data(result_data),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight IDs kept as a queue in issue order.
  bit          m_held;
  logic [31:0] m_instr;
  logic [31:0] m_rs1;
  int          m_hid;
  int          m_next;
  int          q[$];
  bit          m_err;
  bit          m_wbv;
  int          m_wbid;
  logic [31:0] m_wbdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int q_find(input int id);
    for (int i = 0; i < q.size(); i++) if (q[i] == id) return i;
    return -1;
  endfunction

  function automatic bit exp_ready();
    return !m_held && (q.size() < MAXO) && (q_find(m_next) < 0) && !flush;
  endfunction

  // One clock: check combinational outputs for the driven inputs, advance the model, check registered outputs.
  task automatic cycle();
    bit er, acc, fire, hit;
    int idx;
    #1;
    er = exp_ready();
    check("instr_ready", 32'(instr_ready), 32'(er));
    check("issue_valid", 32'(issue_valid), 32'(m_held && !flush));
    check("result_ready", 32'(result_ready), 32'd1);
    if (m_held) begin
      check("issue_id", 32'(issue_id), 32'(m_hid));
      check("issue_instr", issue_instr, m_instr);
      check("issue_rs1", issue_rs1, m_rs1);
    end
    acc  = instr_valid && er;
    fire = m_held && !flush && issue_ready;
    idx  = result_valid ? q_find(int'(result_id)) : -1;
    hit  = (idx >= 0);
    m_wbv = hit && result_we;
    if (m_wbv) begin
      m_wbid   = int'(result_id);
      m_wbdata = result_data;
    end
    if (result_valid && !hit) m_err = 1'b1;
`ifdef FPU_OFFLOAD_INORDER_CHECK_EN
    if (hit && idx != 0) m_err = 1'b1;
`endif
    if (hit) q.delete(idx);
    if (fire) begin
      q.push_back(m_hid);
      m_next = (m_next + 1) % NIDS;
    end
    if (flush || fire) m_held = 1'b0;
    if (acc) begin
      m_held  = 1'b1;
      m_instr = instr;
      m_rs1   = rs1_data;
      m_hid   = m_next;
    end
    @(posedge ck);
    #1;
    check("outstanding", 32'(outstanding), 32'(q.size()));
    check("err", 32'(err), 32'(m_err));
    check("wb_valid", 32'(wb_valid), 32'(m_wbv));
    if (m_wbv) begin
      check("wb_id", 32'(wb_id), 32'(m_wbid));
      check("wb_data", wb_data, m_wbdata);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    result_valid = 1'b0; result_we = 1'b0; instr = '0; rs1_data = '0;
    result_id = '0; result_data = '0;
    @(posedge ck); @(posedge ck); #1;
    check("rst_instr_ready", 32'(instr_ready), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_id", 32'(issue_id), 32'd0);
    check("rst_issue_instr", issue_instr, 32'd0);
    check("rst_issue_rs1", issue_rs1, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_id", 32'(wb_id), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    m_held = 1'b0; m_next = 0; q.delete(); m_err = 1'b0; m_wbv = 1'b0;
    #1;
    check("post_rst_instr_ready", 32'(instr_ready), 32'd1);
  endtask

  task automatic issue_one(input logic [31:0] iw, input logic [31:0] op);
    instr = iw; rs1_data = op; instr_valid = 1'b1; issue_ready = 1'b1;
    cycle();
    instr_valid = 1'b0;
    cycle();
  endtask

  task automatic retire(input int id, input bit we, input logic [31:0] data);
    result_valid = 1'b1; result_id = IDW'(id); result_we = we; result_data = data;
    cycle();
    result_valid = 1'b0;
  endtask

  initial begin
    // Basic issue and writeback
    do_reset();
    instr = 32'h00B50553; rs1_data = 32'd5; instr_valid = 1'b1; issue_ready = 1'b1;
    cycle();
    instr_valid = 1'b0;
    #1;
    check("t1_issue_valid", 32'(issue_valid), 32'd1);
    check("t1_issue_id", 32'(issue_id), 32'd0);
    cycle();
    check("t1_outstanding_1", 32'(outstanding), 32'd1);
    retire(0, 1'b1, 32'h3F800000);
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_data", wb_data, 32'h3F800000);
    check("t1_outstanding_0", 32'(outstanding), 32'd0);
    cycle();
    check("t1_wb_pulse_end", 32'(wb_valid), 32'd0);

    // Stall: held word stays stable while the core keeps presenting new ones
    instr = $urandom; rs1_data = $urandom; instr_valid = 1'b1; issue_ready = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      instr = $urandom;
      cycle();
      check("t2_stall_id", 32'(issue_id), 32'd1);
      check("t2_stall_ready", 32'(instr_ready), 32'd0);
    end
    instr_valid = 1'b0; issue_ready = 1'b1;
    cycle();
    check("t2_outstanding", 32'(outstanding), 32'd1);
    retire(1, 1'b1, $urandom);

    // Fill to MAX_OUTSTANDING, then free one slot
    for (int i = 0; i < 4; i++) issue_one($urandom, $urandom);
    check("t3_full", 32'(outstanding), 32'd4);
    instr_valid = 1'b1;
    #1;
    check("t3_ready_full", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    retire(2, 1'b1, $urandom);
    #1;
    check("t3_ready_freed", 32'(instr_ready), 32'd1);
    for (int id = 3; id <= 5; id++) retire(id, 1'b0, $urandom);

    // ID wrap with in-order retirement, then a stray result
    for (int k = 0; k < 16; k++) begin
      instr = $urandom; rs1_data = $urandom; instr_valid = 1'b1; issue_ready = 1'b1;
      cycle();
      instr_valid = 1'b0;
      #1;
      check("t4_wrap_id", 32'(issue_id), 32'((6 + k) % 16));
      cycle();
      retire((6 + k) % 16, 1'($urandom), $urandom);
    end
    retire(9, 1'b1, 32'hDEADBEEF);
    check("t4_stray_err", 32'(err), 32'd1);
    check("t4_stray_no_wb", 32'(wb_valid), 32'd0);

    // Same-cycle issue and retire; flush of a held instruction
    do_reset();
    issue_one($urandom, $urandom);
    instr = $urandom; instr_valid = 1'b1; issue_ready = 1'b0;
    cycle();
    instr_valid = 1'b0; issue_ready = 1'b1;
    retire(0, 1'b1, $urandom);
    check("t5_fire_and_retire", 32'(outstanding), 32'd1);
    issue_ready = 1'b0; instr = $urandom; instr_valid = 1'b1;
    cycle();
    instr_valid = 1'b0; flush = 1'b1;
    #1;
    check("t5_flush_issue_valid", 32'(issue_valid), 32'd0);
    cycle();
    flush = 1'b0; issue_ready = 1'b1; instr = $urandom; instr_valid = 1'b1;
    cycle();
    instr_valid = 1'b0;
    #1;
    check("t5_id_after_flush", 32'(issue_id), 32'd2);
    cycle();

    // Out-of-order retirement
    do_reset();
    issue_one($urandom, $urandom);
    issue_one($urandom, $urandom);
    retire(1, 1'b1, 32'h11111111);
    check("t6_wb1", 32'(wb_valid), 32'd1);
    retire(0, 1'b1, 32'h22222222);
    check("t6_wb0", 32'(wb_valid), 32'd1);
`ifdef FPU_OFFLOAD_INORDER_CHECK_EN
    check("t6_order_err", 32'(err), 32'd1);
`else
    check("t6_order_err", 32'(err), 32'd0);
`endif

    // Random legal traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      instr_valid = 1'($urandom);
      instr       = $urandom;
      rs1_data    = $urandom;
      issue_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        result_valid = 1'b1;
`ifdef FPU_OFFLOAD_INORDER_CHECK_EN
        result_id = IDW'(q[0]);
`else
        result_id = IDW'(q[$urandom_range(0, q.size() - 1)]);
`endif
        result_we   = 1'($urandom);
        result_data = $urandom;
      end else begin
        result_valid = 1'b0;
      end
      cycle();
    end
    check("rand_no_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
